// File: rtl/fsm_arb_pkg.sv
// ---------------------------------------------------------------------------
// fsm_arb_pkg
// Shared types and helpers for the round-robin grant arbiter.
//   state_t  : arbiter FSM encoding (IDLE / GRANT / RECOVER)
//   idx_w()  : width of a requester index for a given requester count
//   N_REQ_DEF, MAX_HOLD_DEF : default parameter values
// ---------------------------------------------------------------------------
package fsm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT   = 2'b01,
      RECOVER = 2'b10
   } state_t;

   localparam int unsigned N_REQ_DEF    = 4;
   localparam int unsigned MAX_HOLD_DEF = 16;

   // Index width; never below 1 so a degenerate count still yields a legal vector.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: scans req starting just after 'last',
// wrapping modulo N_REQ and ending at 'last'. First set bit wins.
// Ports:
//   req    [N_REQ-1:0] in  request levels
//   last   [W-1:0]     in  most recent owner (lowest priority)
//   found              out at least one request is set
//   winner [W-1:0]     out index of the winning requester
// ---------------------------------------------------------------------------
module rr_pick
   import fsm_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0]          req,
   input  logic [idx_w(N_REQ)-1:0]   last,
   output logic                      found,
   output logic [idx_w(N_REQ)-1:0]   winner
);

   localparam int unsigned W = idx_w(N_REQ);

   int unsigned w_idx;

   // The modulo keeps every probed index below N_REQ, so unused encodings
   // of a non-power-of-two count are never selected.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      w_idx  = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         w_idx = (32'(last) + k) % N_REQ;
         if (!found && req[w_idx]) begin
            found  = 1'b1;
            winner = W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fsm_rr_arbiter
// Round-robin arbiter with level request/grant handshake, a one-cycle
// turnaround (RECOVER) between owners and an optional tenure limit.
// Optional feature macro: FSM_RR_ARBITER_TIMEOUT_EN (hold counter + timeout).
// Ports:
//   clock              in  rising-edge clock
//   reset              in  asynchronous active-low reset
//   req     [N_REQ-1:0] in  request levels
//   gnt     [N_REQ-1:0] out registered one-hot/zero grant
//   gnt_vld            out registered, any grant active
//   gnt_id  [W-1:0]     out current / last owner index
//   timeout            out one-cycle pulse when a tenure is forcibly ended
// ---------------------------------------------------------------------------
module fsm_rr_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         gnt,
   output logic                     gnt_vld,
   output logic [idx_w(N_REQ)-1:0]  gnt_id,
   output logic                     timeout
);

   localparam int unsigned W = idx_w(N_REQ);

   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
      $error("fsm_rr_arbiter: N_REQ out of range 2..16");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("fsm_rr_arbiter: MAX_HOLD out of range 2..255");
   end

   state_t           r_state, w_state_nxt;
   logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
   logic             r_gnt_vld, w_gnt_vld_nxt;
   logic [W-1:0]     r_gnt_id, w_gnt_id_nxt;
   logic [W-1:0]     r_last, w_last_nxt;
   logic             w_found;
   logic [W-1:0]     w_winner;
   logic             w_owner_req;

`ifdef FSM_RR_ARBITER_TIMEOUT_EN
   logic [7:0]       r_hold, w_hold_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             w_limit;

   assign w_limit = (r_hold == 8'(MAX_HOLD - 1));
`endif

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req    (req),
      .last   (r_last),
      .found  (w_found),
      .winner (w_winner)
   );

   assign w_owner_req = req[r_gnt_id];

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_vld_nxt = r_gnt_vld;
      w_gnt_id_nxt  = r_gnt_id;
      w_last_nxt    = r_last;
`ifdef FSM_RR_ARBITER_TIMEOUT_EN
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         GRANT: begin
`ifdef FSM_RR_ARBITER_TIMEOUT_EN
            w_hold_nxt = r_hold + 8'd1;
`endif
            // Release wins over the limit, so a simultaneous drop is a
            // normal release without a timeout pulse.
            if (!w_owner_req) begin
               w_state_nxt   = RECOVER;
               w_gnt_nxt     = '0;
               w_gnt_vld_nxt = 1'b0;
            end
`ifdef FSM_RR_ARBITER_TIMEOUT_EN
            else if (w_limit) begin
               w_state_nxt   = RECOVER;
               w_gnt_nxt     = '0;
               w_gnt_vld_nxt = 1'b0;
               w_timeout_nxt = 1'b1;
            end
`endif
         end
         default: begin
            // IDLE and RECOVER arbitrate identically; in RECOVER the old
            // owner already sits at 'last' and so has lowest priority.
            if (w_found) begin
               w_state_nxt          = GRANT;
               w_gnt_nxt            = '0;
               w_gnt_nxt[w_winner]  = 1'b1;
               w_gnt_vld_nxt        = 1'b1;
               w_gnt_id_nxt         = w_winner;
               w_last_nxt           = w_winner;
`ifdef FSM_RR_ARBITER_TIMEOUT_EN
               w_hold_nxt           = '0;
`endif
            end else begin
               w_state_nxt   = IDLE;
               w_gnt_nxt     = '0;
               w_gnt_vld_nxt = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_gnt_vld <= 1'b0;
         r_gnt_id  <= '0;
         r_last    <= W'(N_REQ - 1);
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_vld <= w_gnt_vld_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_last    <= w_last_nxt;
      end
   end

`ifdef FSM_RR_ARBITER_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   assign gnt     = r_gnt;
   assign gnt_vld = r_gnt_vld;
   assign gnt_id  = r_gnt_id;

endmodule

// File: doc/fsm_rr_arbiter.md
# fsm_rr_arbiter

Round-robin arbiter that shares one downstream resource among `N_REQ` requesters with level-sensitive request/grant handshakes. It replaces fixed-priority grant FSMs, guaranteeing fairness, a one-cycle turnaround gap between owners and an optional tenure limit. It sits between the requesting agents and the shared resource's mux select.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..16.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per tenure, range 2..255. Used only with the timeout feature.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level, held high for as long as ownership is wanted.
- `gnt`  out  N_REQ  one-hot or zero grant, registered.
- `gnt_vld`  out  1  high when any `gnt` bit is high, registered.
- `gnt_id`  out  clog2(N_REQ)  index of the current owner. Holds the last owner when `gnt_vld`=0.
- `timeout`  out  1  one-cycle pulse when a tenure is forcibly ended. Tied to 0 without the macro.

## Operation
- States:
  - IDLE (no owner).
  - GRANT (one owner).
  - RECOVER (one-cycle turnaround, `gnt`=0).
- Pointer `last` (clog2(N_REQ) bits) records the most recent owner.
- Arbitration searches `req` starting at `last+1`, wraps modulo N_REQ, and ends at `last`. The first set bit wins.
- With N_REQ not a power of two, indices ≥ N_REQ are skipped.
- IDLE:
  - any `req` set → GRANT with the winner; `gnt[winner]`, `gnt_vld`, `gnt_id` and `last` load at the next edge.
  - else stay in IDLE.
- GRANT:
  - `req[gnt_id]`=0 → RECOVER, and `gnt` clears at the same edge.
  - other requests are ignored while the owner holds.
- RECOVER: arbitrate exactly as in IDLE.
  - winner found → GRANT.
  - else → IDLE.
  - The previous owner is lowest priority here because `last` already points at it.
- Requests may rise or fall in any cycle. `gnt` never changes except at a state transition.
- Reset:
  - state=IDLE, `gnt`=0, `gnt_vld`=0, `gnt_id`=0, `timeout`=0, `last`=N_REQ-1, so requester 0 has first priority.
  - hold counter=0.
  - Reset asserted mid-tenure drops `gnt` immediately (asynchronously).

## Timing
- Request-to-grant latency from IDLE: 1 cycle. A `req` sampled high at edge t gives `gnt` high after edge t.
- Release latency: 1 cycle. A `req` sampled low at edge t gives `gnt` low after edge t.
- Owner-to-owner gap: exactly one cycle with `gnt_vld`=0 (RECOVER).
- Worst-case wait with timeout enabled: (N_REQ-1)·(MAX_HOLD+1) cycles.
- All outputs come directly from flops. There is no combinational path from `req` to any output.

## Configuration
- Macro: `FSM_RR_ARBITER_TIMEOUT_EN`.
- When defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and `req[gnt_id]` is still 1, the FSM goes to RECOVER at the next edge.
  - `timeout` pulses for the single RECOVER cycle.
  - The owner may re-request and is served again after the others through normal round-robin.
  - Release and limit in the same cycle counts as a normal release; `timeout` stays 0.
- When undefined:
  - No counter is present and tenure is unbounded.
  - `timeout` is constant 0.
  - MAX_HOLD is ignored.

## Structure
- Package `fsm_arb_pkg`:
  - state enum (IDLE=2'b00, GRANT=2'b01, RECOVER=2'b10).
  - `clog2`-based index width function.
  - default parameter constants.
- Sub-module `rr_pick`: purely combinational rotate-and-priority-encode.
  - Inputs: `req`, `last`.
  - Outputs: `found`, `winner`.
  - Instantiated once.
- Top level holds only the state register, pointer, counter and output flops.

## Test plan
- Reset then `req`=4'b0000 for 10 cycles → `gnt`=0, `gnt_vld`=0, `gnt_id`=0, `timeout`=0 throughout.
- `req`=4'b1111 held → grant order 0,1,2,3,0. Each requester drops `req` after 3 cycles of grant. Each grant lasts 3 cycles, with one `gnt_vld`=0 cycle between grants.
- `req[2]` rises alone at edge 5 → `gnt`=4'b0100 after edge 5. `req[2]` falls at edge 9 → `gnt`=0 after edge 9, then IDLE.
- With macro, MAX_HOLD=4, `req`=4'b0011 held → `gnt[0]` for 4 cycles, then `timeout`=1 for 1 cycle, then `gnt[1]` for 4 cycles, repeating. Without macro, `gnt[0]` holds indefinitely.
- `reset` asserted asynchronously mid-tenure on `gnt[1]` → `gnt` goes to 0 before the next edge. After release with `req`=4'b1010, requester 1 is granted first.
- N_REQ=3, `last`=2, `req`=3'b100 → grant 2 after 1 cycle, with no out-of-range index selected.
